// File: rtl/mem_writeback_buffer_pkg.sv
// Shared types for the writeback buffer / main-memory model.
package mem_writeback_buffer_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 3;
    localparam int TAG_W  = 3;
    localparam int IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FILL_FWD,
        ST_FILL_MEM
    } state_e;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [IDX_W-1:0]  index;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [ADDR_W-1:0] entry_addr(input wb_entry_t e);
        return {e.tag, e.index};
    endfunction

endpackage

// File: rtl/mem_writeback_buffer_wb_fifo.sv
// Writeback FIFO with occupancy tracking and a youngest-match search port.
module wb_fifo
    import mem_writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    output wb_entry_t                    head_entry,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    input  logic [ADDR_W-1:0]            search_addr,
    output logic                         search_hit,
    output logic [DATA_W-1:0]            search_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        store_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] slot;
    logic             do_push;
    logic             do_pop;

    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign occupancy  = count_q;
    assign head_entry = store_q[head_q];
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop)  head_d = head_q + 1'b1;
        if (do_push) tail_d = tail_q + 1'b1;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Walk from oldest to youngest so the last hit wins.
    always_comb begin
        search_hit  = 1'b0;
        search_data = '0;
        slot        = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && entry_addr(store_q[slot]) == search_addr) begin
                search_hit  = 1'b1;
                search_data = store_q[slot].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) store_q[tail_q] <= push_entry;
    end

endmodule

// File: rtl/mem_writeback_buffer.sv
// Main-memory model fed by a writeback FIFO; serves refills with
// store forwarding from the FIFO or fixed-latency backing-store reads.
module mem_writeback_buffer
    import mem_writeback_buffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int WRITE_LAT = 2,
    parameter int READ_LAT  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wb_valid,
    input  logic [TAG_W-1:0]            wb_tag,
    input  logic [IDX_W-1:0]            wb_index,
    input  logic [DATA_W-1:0]           wb_data,
    output logic                        wb_ready,
    input  logic                        fill_req,
    input  logic [TAG_W-1:0]            fill_tag,
    input  logic [IDX_W-1:0]            fill_index,
    output logic                        fill_busy,
    output logic                        fill_valid,
    output logic [DATA_W-1:0]           fill_data,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy,
    output logic                        overflow
);

    localparam int MAX_LAT = (WRITE_LAT > READ_LAT) ? WRITE_LAT : READ_LAT;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    localparam int WORDS   = 1 << ADDR_W;

    state_e            state_q, state_d;
    logic [LAT_W-1:0]  cnt_q, cnt_d;
    logic              fill_busy_q, fill_busy_d;
    logic              fill_pend_q, fill_pend_d;
    logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
    logic              fill_valid_q, fill_valid_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    logic [DATA_W-1:0] fwd_q, fwd_d;
    logic              overflow_q, overflow_d;
    wb_entry_t         drain_q, drain_d;
    logic [DATA_W-1:0] mem_q [WORDS];

    wb_entry_t         push_entry;
    wb_entry_t         head_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic              search_hit;
    logic [DATA_W-1:0] search_data;
    logic              mem_we;

    assign push_entry = '{tag: wb_tag, index: wb_index, data: wb_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (wb_valid),
        .push_entry  (push_entry),
        .pop         (fifo_pop),
        .head_entry  (head_entry),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .occupancy   (occupancy),
        .search_addr (fill_addr_q),
        .search_hit  (search_hit),
        .search_data (search_data)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fill_busy_d  = fill_busy_q;
        fill_pend_d  = fill_pend_q;
        fill_addr_d  = fill_addr_q;
        fill_valid_d = 1'b0;
        fill_data_d  = fill_data_q;
        fwd_d        = fwd_q;
        overflow_d   = overflow_q;
        drain_d      = drain_q;
        fifo_pop     = 1'b0;
        mem_we       = 1'b0;

        if (fill_req && !fill_busy_q) begin
            fill_busy_d = 1'b1;
            fill_pend_d = 1'b1;
            fill_addr_d = {fill_tag, fill_index};
        end
        if (wb_valid && fifo_full) overflow_d = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                // A waiting refill is decided before any new drain starts.
                if (fill_pend_q) begin
                    fill_pend_d = 1'b0;
                    if (search_hit) begin
                        fwd_d   = search_data;
                        state_d = ST_FILL_FWD;
                    end else begin
                        cnt_d   = LAT_W'(READ_LAT - 1);
                        state_d = ST_FILL_MEM;
                    end
                end else if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    drain_d  = head_entry;
                    cnt_d    = LAT_W'(WRITE_LAT - 1);
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    mem_we  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FILL_FWD: begin
                fill_data_d  = fwd_q;
                fill_valid_d = 1'b1;
                fill_busy_d  = 1'b0;
                state_d      = ST_IDLE;
            end
            ST_FILL_MEM: begin
                if (cnt_q == '0) begin
                    fill_data_d  = mem_q[fill_addr_q];
                    fill_valid_d = 1'b1;
                    fill_busy_d  = 1'b0;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            fill_busy_q  <= 1'b0;
            fill_pend_q  <= 1'b0;
            fill_addr_q  <= '0;
            fill_valid_q <= 1'b0;
            fill_data_q  <= '0;
            fwd_q        <= '0;
            overflow_q   <= 1'b0;
            drain_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fill_busy_q  <= fill_busy_d;
            fill_pend_q  <= fill_pend_d;
            fill_addr_q  <= fill_addr_d;
            fill_valid_q <= fill_valid_d;
            fill_data_q  <= fill_data_d;
            fwd_q        <= fwd_d;
            overflow_q   <= overflow_d;
            drain_q      <= drain_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[entry_addr(drain_q)] <= drain_q.data;
        end
    end

    assign wb_ready   = !fifo_full;
    assign fill_busy  = fill_busy_q;
    assign fill_valid = fill_valid_q;
    assign fill_data  = fill_data_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_mem_writeback_buffer.sv
// Bench for mem_writeback_buffer: directed table, corner sequences, random vs model.
module tb_mem_writeback_buffer;

    localparam int DEPTH     = 4;
    localparam int WRITE_LAT = 2;
    localparam int READ_LAT  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_valid;
    logic [2:0] wb_tag;
    logic [1:0] wb_index;
    logic [2:0] wb_data;
    logic       wb_ready;
    logic       fill_req;
    logic [2:0] fill_tag;
    logic [1:0] fill_index;
    logic       fill_busy;
    logic       fill_valid;
    logic [2:0] fill_data;
    logic [2:0] occupancy;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_writeback_buffer #(
        .DEPTH(DEPTH), .WRITE_LAT(WRITE_LAT), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_index(wb_index),
        .wb_data(wb_data), .wb_ready(wb_ready),
        .fill_req(fill_req), .fill_tag(fill_tag), .fill_index(fill_index),
        .fill_busy(fill_busy), .fill_valid(fill_valid), .fill_data(fill_data),
        .occupancy(occupancy), .overflow(overflow)
    );

    // Reference model: queue of pending writes, flat memory array, and
    // absolute edge numbers at which scheduled events complete.
    typedef struct {
        logic [4:0] a;
        logic [2:0] d;
    } ment_t;

    ment_t      mq[$];
    logic [2:0] mmem [32];
    int         cyc = 0;
    int         eng_free = 0;
    int         out_edge = -1;
    int         wr_edge = -1;
    bit         out_mem;
    logic [2:0] fwd_d, wr_d;
    logic [4:0] wr_a, paddr;
    bit         busy, waiting;
    bit         m_fv;
    logic [2:0] m_fd;
    bit         m_ovf;

    task automatic model_edge();
        int sz0;
        bit busy0;
        bit hit;
        logic [2:0] hd;
        ment_t e;
        cyc++;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 32; i++) mmem[i] = 3'd0;
            busy = 0; waiting = 0; eng_free = 0;
            out_edge = -1; wr_edge = -1;
            m_fv = 0; m_fd = 3'd0; m_ovf = 0;
            return;
        end
        sz0 = mq.size();
        busy0 = busy;
        m_fv = 0;
        if (wr_edge == cyc) begin
            mmem[wr_a] = wr_d;
            wr_edge = -1;
        end
        if (out_edge == cyc) begin
            m_fv = 1;
            m_fd = out_mem ? mmem[paddr] : fwd_d;
            busy = 0;
            out_edge = -1;
        end
        if (cyc >= eng_free) begin
            if (waiting) begin
                hit = 0;
                hd = 3'd0;
                foreach (mq[i]) if (mq[i].a == paddr) begin
                    hit = 1;
                    hd = mq[i].d;
                end
                waiting = 0;
                if (hit) begin
                    fwd_d = hd; out_mem = 0;
                    out_edge = cyc + 1; eng_free = cyc + 2;
                end else begin
                    out_mem = 1;
                    out_edge = cyc + READ_LAT; eng_free = cyc + READ_LAT + 1;
                end
            end else if (sz0 > 0) begin
                e = mq.pop_front();
                wr_a = e.a; wr_d = e.d;
                wr_edge = cyc + WRITE_LAT; eng_free = cyc + WRITE_LAT + 1;
            end
        end
        if (wb_valid) begin
            if (sz0 == DEPTH) m_ovf = 1;
            else mq.push_back('{a: {wb_tag, wb_index}, d: wb_data});
        end
        if (fill_req && !busy0) begin
            busy = 1; waiting = 1;
            paddr = {fill_tag, fill_index};
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("fill_valid", fill_valid, m_fv);
        chk("fill_data", fill_data, m_fd);
        chk("fill_busy", fill_busy, busy);
        chk("occupancy", occupancy, mq.size());
        chk("wb_ready", wb_ready, mq.size() < DEPTH);
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic idle();
        rst = 0; wb_valid = 0; wb_tag = 0; wb_index = 0; wb_data = 0;
        fill_req = 0; fill_tag = 0; fill_index = 0;
    endtask

    task automatic push(input logic [2:0] t, input logic [1:0] i, input logic [2:0] d);
        wb_valid = 1; wb_tag = t; wb_index = i; wb_data = d;
    endtask

    task automatic req(input logic [2:0] t, input logic [1:0] i);
        fill_req = 1; fill_tag = t; fill_index = i;
    endtask

    task automatic wait_fill(input string name, input int exp, input int budget);
        int n = 0;
        idle();
        do begin
            step();
            n++;
        end while (!fill_valid && n < budget);
        chk(name, fill_valid ? int'(fill_data) : -1, exp);
    endtask

    typedef struct {
        logic       rst, wv;
        logic [2:0] wt;
        logic [1:0] wi;
        logic [2:0] wd;
        logic       fr;
        logic [2:0] ft;
        logic [1:0] fi;
        logic       ev;
        logic [2:0] ed;
        logic       eb;
        logic [2:0] eo;
        logic       erdy, eovf;
    } vec_t;

    vec_t tbl [18];

    function automatic vec_t mk(
        input logic r, input logic wv, input logic [2:0] wt, input logic [1:0] wi,
        input logic [2:0] wd, input logic fr, input logic [2:0] ft, input logic [1:0] fi,
        input logic ev, input logic [2:0] ed, input logic eb, input logic [2:0] eo,
        input logic erdy, input logic eovf);
        vec_t v;
        v.rst = r; v.wv = wv; v.wt = wt; v.wi = wi; v.wd = wd;
        v.fr = fr; v.ft = ft; v.fi = fi;
        v.ev = ev; v.ed = ed; v.eb = eb; v.eo = eo; v.erdy = erdy; v.eovf = eovf;
        return v;
    endfunction

    initial begin
        int pulses;
        idle();
        rst = 1;

        // Forward hit: push+request at T, pulse at T+2; then a drain.
        tbl[0]  = mk(1, 0,0,0,0, 0,0,0,  0,0,0,0,1,0);
        tbl[1]  = mk(0, 1,6,2,5, 1,6,2,  0,0,1,1,1,0);
        tbl[2]  = mk(0, 0,0,0,0, 0,0,0,  0,0,1,1,1,0);
        tbl[3]  = mk(0, 0,0,0,0, 0,0,0,  1,5,0,1,1,0);
        tbl[4]  = mk(0, 0,0,0,0, 0,0,0,  0,5,0,0,1,0);
        tbl[5]  = mk(0, 0,0,0,0, 0,0,0,  0,5,0,0,1,0);
        tbl[6]  = mk(0, 0,0,0,0, 0,0,0,  0,5,0,0,1,0);
        tbl[7]  = mk(0, 0,0,0,0, 0,0,0,  0,5,0,0,1,0);
        // Drained write read back from memory: pulse at T+4.
        tbl[8]  = mk(0, 1,0,1,3, 0,0,0,  0,5,0,1,1,0);
        tbl[9]  = mk(0, 0,0,0,0, 0,0,0,  0,5,0,0,1,0);
        tbl[10] = mk(0, 0,0,0,0, 0,0,0,  0,5,0,0,1,0);
        tbl[11] = mk(0, 0,0,0,0, 0,0,0,  0,5,0,0,1,0);
        tbl[12] = mk(0, 0,0,0,0, 1,0,1,  0,5,1,0,1,0);
        tbl[13] = mk(0, 0,0,0,0, 0,0,0,  0,5,1,0,1,0);
        tbl[14] = mk(0, 0,0,0,0, 0,0,0,  0,5,1,0,1,0);
        tbl[15] = mk(0, 0,0,0,0, 0,0,0,  0,5,1,0,1,0);
        tbl[16] = mk(0, 0,0,0,0, 0,0,0,  1,3,0,0,1,0);
        tbl[17] = mk(0, 0,0,0,0, 0,0,0,  0,3,0,0,1,0);

        for (int k = 0; k < 18; k++) begin
            rst = tbl[k].rst;
            wb_valid = tbl[k].wv; wb_tag = tbl[k].wt;
            wb_index = tbl[k].wi; wb_data = tbl[k].wd;
            fill_req = tbl[k].fr; fill_tag = tbl[k].ft; fill_index = tbl[k].fi;
            step();
            chk($sformatf("tbl%0d_valid", k), fill_valid, tbl[k].ev);
            chk($sformatf("tbl%0d_data", k), fill_data, tbl[k].ed);
            chk($sformatf("tbl%0d_busy", k), fill_busy, tbl[k].eb);
            chk($sformatf("tbl%0d_occ", k), occupancy, tbl[k].eo);
            chk($sformatf("tbl%0d_ready", k), wb_ready, tbl[k].erdy);
            chk($sformatf("tbl%0d_ovf", k), overflow, tbl[k].eovf);
        end

        // Fill the FIFO while a memory refill holds off draining.
        idle(); req(0, 0); push(7, 3, 1); step();
        fill_req = 0; step(); step(); step();
        chk("occ_full", occupancy, 4);
        chk("ready_full", wb_ready, 0);
        step();
        chk("ovf_set", overflow, 1);
        chk("occ_hold", occupancy, 4);
        idle();
        repeat (15) step();
        chk("drained_all", occupancy, 0);

        // Two queued writes to one address: youngest is forwarded.
        push(2, 0, 6); step();
        push(5, 1, 2); step();
        push(5, 1, 7); req(5, 1); step();
        wait_fill("youngest_fwd", 7, 10);
        idle(); repeat (15) step();

        // Refill arriving during a drain waits for the write to land.
        push(3, 2, 4); step();
        idle(); step();
        req(3, 2); step();
        req(1, 1); step();
        wait_fill("drain_then_fill", 4, 10);
        pulses = 0;
        repeat (10) begin
            step();
            if (fill_valid) pulses++;
        end
        chk("no_second_pulse", pulses, 0);

        // Reset in the middle of a memory refill.
        req(3, 2); step();
        idle(); step();
        rst = 1; step();
        rst = 0;
        chk("rst_valid", fill_valid, 0);
        chk("rst_busy", fill_busy, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_data", fill_data, 0);
        chk("rst_ovf", overflow, 0);
        req(3, 2); step();
        wait_fill("post_reset_zero", 0, 10);
        idle(); repeat (5) step();

        // Random traffic over a small address pool to get frequent hits.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            wb_valid = ($urandom_range(0, 9) < 4);
            wb_tag = 3'($urandom_range(0, 1));
            wb_index = 2'($urandom_range(0, 3));
            wb_data = 3'($urandom_range(0, 7));
            fill_req = ($urandom_range(0, 9) < 3);
            fill_tag = 3'($urandom_range(0, 1));
            fill_index = 2'($urandom_range(0, 3));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_writeback_buffer.md
Name: mem_writeback_buffer

Overview:
- Downstream neighbour of the 2-way cache. It consumes writeback (dirty-victim) events and refill requests, and models main memory.
- Evicted lines are queued in a small FIFO and drained into a 32-entry backing store, one write at a time, with a fixed write latency.
- Refill reads return data after a fixed read latency. A read is serviced directly from the FIFO when it holds a newer copy of the address (store forwarding).
- Memory address = {tag[2:0], index[1:0]}, so 5 bits. Data is 3 bits.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, at least 2).
- WRITE_LAT, 2, cycles per drain write to backing store (at least 1).
- READ_LAT, 3, cycles from refill start to data for a non-forwarded read (at least 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset.
- wb_valid  in  1  cache offers a writeback entry this cycle.
- wb_tag  in  3  tag of evicted line.
- wb_index  in  2  index of evicted line.
- wb_data  in  3  data of evicted line.
- wb_ready  out  1  FIFO can accept; equals !full.
- fill_req  in  1  refill request, sampled when fill_busy=0.
- fill_tag  in  3  refill tag.
- fill_index  in  2  refill index.
- fill_busy  out  1  refill pending or in progress.
- fill_valid  out  1  one-cycle pulse; fill_data valid.
- fill_data  out  3  refill data, held until the next fill_valid.
- occupancy  out  3  FIFO entry count, 0..DEPTH.
- overflow  out  1  sticky; set when wb_valid is high while full.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: FIFO empty, occupancy=0, wb_ready=1, fill_busy=0, fill_valid=0, fill_data=0, overflow=0, FSM=IDLE, counters=0. All 32 backing-store words are cleared to 0.
- Reset mid-operation: any drain or refill in flight is abandoned, FIFO contents are lost, and no fill_valid pulse is produced.
- Push: wb_valid && !full writes {tag,index,data} at the tail.
  - wb_valid while full: the entry is dropped and overflow is set to 1.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - Head and tail pointers wrap modulo DEPTH.
- Refill accept: fill_req && !fill_busy at edge T latches the address, and fill_busy=1 from T+1.
  - fill_req while busy is ignored.
- FSM states: IDLE, DRAIN, FILL_FWD, FILL_MEM.
  - IDLE, pending refill: address search over valid FIFO entries, including any entry pushed in the accept cycle.
    - Match: go to FILL_FWD, taking the youngest matching entry's data.
    - No match: go to FILL_MEM with the counter loaded to READ_LAT-1.
    - A pending refill always beats starting a drain.
  - IDLE, no pending refill, FIFO not empty: pop the head into a drain register, load the counter with WRITE_LAT-1, go to DRAIN.
  - DRAIN: count down. When the count reaches 0, write the drain register into the backing store and return to IDLE.
    - A drain is never aborted. A refill accepted during DRAIN waits until the drain completes.
  - FILL_FWD: fill_data = forwarded data, fill_valid=1 for one cycle, fill_busy clears, return to IDLE.
  - FILL_MEM: count down. When the count reaches 0, fill_data = backing store word, fill_valid=1, fill_busy clears, return to IDLE.
- Latency from the accept edge T, with the FSM idle:
  - Forward hit: fill_valid at T+2.
  - Memory read: fill_valid at T+1+READ_LAT.
- Coherence guarantee: a refill always returns the most recent value written by a writeback to that address, whether it is still queued or already drained.
- Pushes continue during FILL and DRAIN states.

Decomposition:
- Shared package:
  - ADDR_W=5, DATA_W=3, TAG_W=3, IDX_W=2.
  - FSM state encoding.
  - Packed writeback-entry type {tag,index,data}.
- Sub-module wb_fifo: storage, pointers, occupancy, full/empty, and a combinational youngest-match search port.
- The top level holds the FSM, latency counter and backing store.

Test Plan:
- Reset, then push (tag=110, idx=10, data=101), then fill_req for the same address: fill_valid at T+2 with fill_data=101, and occupancy is 1 or 0 depending on drain timing.
- Push 4 entries back-to-back: occupancy=4, wb_ready=0. A 5th wb_valid sets overflow=1 and leaves occupancy at 4. Drains complete every WRITE_LAT+1 cycles until empty.
- Push addr 00001 data 011, let it drain, then fill addr 00001: fill_valid at T+4 with fill_data=011 (READ_LAT=3).
- Push the same address twice (data 010 then 111), then fill immediately: fill_data=111 (youngest match).
- Refill issued while DRAIN is in its first cycle: the drain write lands first, and fill_valid follows with the correct data. fill_req during busy is ignored (no second pulse).
- rst asserted mid-FILL_MEM: next cycle all outputs are at reset values, no fill_valid, and a later fill of any address returns 0.
